// File: rtl/approx_mul_pkg.sv
// rtl/approx_mul_pkg.sv - shared types and defaults for the approximate multiplier datapath
// Contents: state_t (2-bit FSM state, also used by the separator stage for debug),
//           DEF_DATA_W, DEF_SHIFT_W, DEF_MAX_SHIFT defaults.
package approx_mul_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_SHIFT_W   = 5;
    localparam int DEF_MAX_SHIFT = 2 * DEF_DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/result_shifter.sv
// rtl/result_shifter.sv - combinational barrel left shift of the exact product
// Ports: product_i (2*DATA_W) exact product, shift_i (SHIFT_W) pre-clamped shift,
//        shifted_o (4*DATA_W) zero-extended product shifted left.
module result_shifter #(
    parameter int DATA_W  = 8,
    parameter int SHIFT_W = 5
) (
    input  logic [2*DATA_W-1:0] product_i,
    input  logic [SHIFT_W-1:0]  shift_i,
    output logic [4*DATA_W-1:0] shifted_o
);

    localparam int RES_W = 4 * DATA_W;

    // One mux rank per shift bit; rank k shifts by 2**k when that bit is set.
    logic [RES_W-1:0] rank [SHIFT_W+1];

    always_comb begin
        rank[0] = {{(2*DATA_W){1'b0}}, product_i};
        for (int k = 0; k < SHIFT_W; k++) begin
            rank[k+1] = shift_i[k] ? (rank[k] << (1 << k)) : rank[k];
        end
    end

    assign shifted_o = rank[SHIFT_W];

endmodule

// File: rtl/approx_combiner.sv
// rtl/approx_combiner.sv - sequential shift-add multiply then left shift to rebuild the approximate product
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a_i, b_i, shift_i;
//        out_valid/out_ready with result_o; busy_o high while multiplying or shifting.
module approx_combiner
    import approx_mul_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SHIFT_W   = DEF_SHIFT_W,
    parameter int MAX_SHIFT = DEF_MAX_SHIFT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic [SHIFT_W-1:0]  shift_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DATA_W-1:0] result_o,
    output logic                busy_o
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int RES_W  = 4 * DATA_W;
    localparam int CNT_W  = $clog2(DATA_W);

    state_t              state;
    state_t              state_next;

    logic [PROD_W-1:0]   mcand;
    logic [DATA_W-1:0]   mplier;
    logic [PROD_W-1:0]   acc;
    logic [CNT_W-1:0]    iter_cnt;
    logic [SHIFT_W-1:0]  shift_reg;
    logic [RES_W-1:0]    result_q;
    logic [RES_W-1:0]    shifted;
    logic [SHIFT_W-1:0]  shift_clamped;
    logic                last_iter;
    logic                capture;

    assign shift_clamped = (shift_i > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : shift_i;
    assign last_iter     = (iter_cnt == CNT_W'(DATA_W - 1));
    assign capture       = (state == ST_IDLE) && in_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs. in_ready is masked by rst so it reads
    // low while reset is held even though the state is already IDLE.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy_o     = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_next = ST_MUL;
                end
            end
            ST_MUL: begin
                busy_o = 1'b1;
                if (last_iter) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy_o     = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath. The multiplicand walks left while the multiplier walks right,
    // so bit 0 of mplier is always the current iteration's multiplier bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            iter_cnt  <= '0;
            shift_reg <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (capture) begin
                        mcand     <= {{DATA_W{1'b0}}, a_i};
                        mplier    <= b_i;
                        acc       <= '0;
                        iter_cnt  <= '0;
                        shift_reg <= shift_clamped;
                    end
                end
                ST_MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand    <= mcand << 1;
                    mplier   <= mplier >> 1;
                    iter_cnt <= iter_cnt + CNT_W'(1);
                end
                ST_SHIFT: begin
                    result_q <= shifted;
                end
                default: begin
                end
            endcase
        end
    end

    result_shifter #(
        .DATA_W  (DATA_W),
        .SHIFT_W (SHIFT_W)
    ) u_result_shifter (
        .product_i (acc),
        .shift_i   (shift_reg),
        .shifted_o (shifted)
    );

    assign result_o = result_q;

endmodule

// File: tb/tb_approx_combiner.sv
// tb/tb_approx_combiner.sv - self-checking bench for approx_combiner
module tb_approx_combiner;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic [4:0]  shift_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    approx_combiner dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .shift_i   (shift_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_o  (result_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [7:0] a, input logic [7:0] b, input logic [4:0] s);
        int unsigned sh;
        logic [31:0] p;
        sh = (s > 5'd16) ? 16 : int'(s);
        p  = 32'(a) * 32'(b);
        return p << sh;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait for its result, with hold cycles of backpressure.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [4:0] s, input int hold);
        logic [31:0] exp;
        int          n;
        logic        busy_ok;
        logic        hold_ok;
        exp       = model(a, b, s);
        out_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_ready_in"}, 32'(in_ready), 32'd1);
        a_i      = a;
        b_i      = b;
        shift_i  = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a_i      = 8'($urandom);
        b_i      = 8'($urandom);
        shift_i  = 5'($urandom);
        n        = 0;
        busy_ok  = 1'b1;
        while (!out_valid && n < 20) begin
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd9);
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check({tag, "_result"}, result_o, exp);
        check({tag, "_busy_done"}, 32'(busy_o), 32'd0);
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        if (hold > 0) begin
            hold_ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (out_valid !== 1'b1 || result_o !== exp || in_ready !== 1'b0) hold_ok = 1'b0;
            end
            check({tag, "_hold"}, 32'(hold_ok), 32'd1);
            out_ready = 1'b1;
        end
        tick();
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] got[$];
        logic [31:0] e1;
        logic [31:0] e2;
        int          cyc;
        int          cap2;
        logic        never_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a_i       = '0;
        b_i       = '0;
        shift_i   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        run_op("max", 8'hFF, 8'hFF, 5'd0, 0);
        check("max_const", model(8'hFF, 8'hFF, 5'd0), 32'h0000FE01);
        run_op("full16", 8'hB4, 8'h80, 5'd16, 0);
        run_op("clamp20", 8'hB4, 8'h80, 5'd20, 0);
        run_op("zero", 8'h00, 8'h7F, 5'd5, 0);
        run_op("bp", 8'h03, 8'h05, 5'd4, 6);

        // Reset sampled at E4 of an operation.
        out_ready = 1'b1;
        a_i       = 8'h10;
        b_i       = 8'h10;
        shift_i   = 5'd2;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_result", result_o, 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        never_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy_o !== 1'b0) never_valid = 1'b0;
        end
        check("mid_rst_quiet", 32'(never_valid), 32'd1);
        run_op("after_rst", 8'h02, 8'h03, 5'd1, 0);

        // Back-to-back with in_valid held high.
        e1        = model(8'h12, 8'h34, 5'd3);
        e2        = model(8'h56, 8'h78, 5'd7);
        out_ready = 1'b1;
        a_i       = 8'h12;
        b_i       = 8'h34;
        shift_i   = 5'd3;
        in_valid  = 1'b1;
        tick();
        a_i     = 8'h56;
        b_i     = 8'h78;
        shift_i = 5'd7;
        cyc     = 0;
        cap2    = -1;
        while (got.size() < 2 && cyc < 40) begin
            if (out_valid) got.push_back(result_o);
            if (in_valid && in_ready && cap2 < 0) cap2 = cyc + 1;
            tick();
            cyc++;
            if (cap2 == cyc) in_valid = 1'b0;
        end
        check("b2b_capture_edge", 32'(cap2), 32'd11);
        check("b2b_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check("b2b_first", got[0], e1);
            check("b2b_second", got[1], e2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op("rand", 8'($urandom), 8'($urandom), 5'($urandom_range(0, 31)),
                   int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/approx_combiner.md
# approx_combiner

Back-end of the approximate multiplier datapath. It accepts the two 8-bit truncated operand fragments and the total discarded-bit count produced by the operand separator stage. It forms their exact 16-bit product with a sequential shift-add multiplier, then left-shifts the product by the discarded-bit count to reconstruct the 32-bit approximate product. Input and output each use a valid/ready handshake, so the block sits between the separator stage and the result consumer.

## Interface
- DATA_W, 8, fragment width; product is 2*DATA_W bits, result is 4*DATA_W bits
- SHIFT_W, 5, width of the discarded-bit count
- MAX_SHIFT, 16, largest legal shift (2*DATA_W)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand fragments and shift valid
- in_ready  out  1  block can accept; high only in IDLE
- a_i  in  DATA_W  fragment of operand 1
- b_i  in  DATA_W  fragment of operand 2
- shift_i  in  SHIFT_W  total discarded bits (sum of both operands)
- out_valid  out  1  result_o valid
- out_ready  in  1  consumer accepts result
- result_o  out  4*DATA_W  reconstructed product
- busy_o  out  1  high in MUL or SHIFT

## Operation
- FSM states: IDLE, MUL, SHIFT, DONE.
- IDLE: in_ready=1. If in_valid, capture a_i, b_i and clamped shift, clear the accumulator and the 3-bit iteration counter, then go to MUL.
- MUL: one iteration per cycle, LSB-first. If the current multiplier bit is 1, add the shifted multiplicand into the 2*DATA_W-bit accumulator, then advance. After exactly DATA_W iterations, go to SHIFT. There is no early exit, so a zero operand still takes full latency.
- SHIFT: result_o <= zero-extended product << shift_reg. Set out_valid and go to DONE.
- DONE: hold result_o and out_valid stable until out_ready=1. On that edge, clear out_valid and return to IDLE. result_o keeps its value but is don't-care while out_valid=0.
- Shift clamp: shift_i > MAX_SHIFT is treated as MAX_SHIFT. No error flag.
- Width rule: the accumulator is 2*DATA_W bits and never overflows, since (2^DATA_W−1)² < 2^(2*DATA_W). The result is 4*DATA_W bits. A shift of 16 on a maximal product fits without truncation.
- in_ready has no combinational path from out_ready. The next operand can be taken only after the return to IDLE.
- Reset values: in_ready=0 during rst and 1 after reset release, because the state is IDLE. out_valid=0, result_o=0, busy_o=0, accumulator, counter and shift_reg all 0.
- Reset mid-operation from any state: abandon the operation. No result is emitted and the block returns to IDLE.

## Timing
- E0 is the edge where in_valid&in_ready=1 (capture).
- E1..E8 are the MUL iterations.
- E9 is the SHIFT edge. out_valid is high in the cycle after E9, giving a latency of 9 cycles.
- If out_ready=1 already, the handshake completes at E10. in_ready is high again after E10, so the next capture is possible at E11. Minimum initiation interval is 11 cycles.
- in_valid in any state other than IDLE is ignored. The upstream stage must hold its data until in_ready.
- If rst and any handshake fall on the same edge, rst wins.

## Structure
- Shared package approx_mul_pkg holds:
  - the state enum (IDLE, MUL, SHIFT, DONE)
  - the DATA_W and MAX_SHIFT defaults
  - the 2-bit state type, which the separator stage also uses for debug
- One sub-module: result_shifter. It is a combinational barrel left shift, product (2*DATA_W) by shift (SHIFT_W, pre-clamped) to 4*DATA_W, instantiated once and registered in SHIFT.

## Test plan
- Max operands: a=0xFF, b=0xFF, shift=0, out_ready=1 → result_o=0x0000FE01, out_valid high in the cycle after E9, for exactly one cycle.
- Full shift: a=0xB4, b=0x80, shift=16 → result_o=0x5A000000. Repeating with shift=20 must give the same 0x5A000000 (clamp).
- Zero operand: a=0x00, b=0x7F, shift=5 → result_o=0x00000000 at the same 9-cycle latency, with busy_o high for cycles 1–9.
- Backpressure: a=0x03, b=0x05, shift=4, out_ready low for 6 cycles → result_o=0x000000F0 held stable with out_valid=1 and in_ready=0 throughout. in_ready returns to 1 one cycle after out_ready rises.
- Reset mid-op: assert rst at E4 of a=0x10, b=0x10 → out_valid never rises, all outputs 0, and in_ready=1 after release. A new op a=0x02, b=0x03, shift=1 then yields 0x0000000C.
- Back-to-back: in_valid held high with two operand sets → the second is captured only at E11. Both results are correct and in order.
